// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state encoding for the MAC TX arbiter
package mac_pkg;

  // Default inter-frame gap in bytes
  localparam int IFG_N_DEF = 12;

  // One-hot scheduler states
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SEND = 3'b010,
    ST_IFG  = 3'b100
  } tx_state_e;

  // Integer ceiling division, used to turn the byte gap into clock cycles
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mac_rr_pick.sv
// rtl/mac_rr_pick.sv - combinational rotate-priority pick starting at the round-robin pointer
module mac_rr_pick
  import mac_pkg::*;
#(
  parameter int REQ_N = 2,
  parameter int RR_W  = 1
) (
  input  logic [REQ_N-1:0] req,
  input  logic [RR_W-1:0]  rr_ptr,
  output logic [REQ_N-1:0] pick,
  output logic             any
);

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-two REQ_N works
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= REQ_N) begin
        idx = idx - REQ_N;
      end
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - frame-granular round-robin scheduler for the shared MAC TX datapath
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int REQ_N  = 2,
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int IFG_N  = IFG_N_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ_N-1:0]          req_valid_i,
  input  logic [REQ_N*DATA_W-1:0]   req_data_i,
  input  logic [REQ_N*KEEP_W-1:0]   req_keep_i,
  input  logic [REQ_N-1:0]          req_last_i,
  input  logic [REQ_N-1:0]          req_cancel_i,
  output logic [REQ_N-1:0]          req_ready_o,
  input  logic                      mac_ready_i,
  output logic                      mac_valid_o,
  output logic [DATA_W-1:0]         mac_data_o,
  output logic [KEEP_W-1:0]         mac_keep_o,
  output logic                      mac_last_o,
  output logic                      mac_cancel_o,
  output logic [REQ_N-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int IFG_CYC = ceil_div(IFG_N, KEEP_W);
  localparam int CNT_W   = $clog2(IFG_CYC + 1);
  localparam int RR_W    = $clog2(REQ_N);

  localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_CYC - 1);
  localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(REQ_N - 1);

  tx_state_e          state_q, state_d;
  logic [RR_W-1:0]    rr_q, rr_d;
  logic [REQ_N-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   ifg_cnt_q, ifg_cnt_d;

  logic [REQ_N-1:0]   pick;
  logic               pick_any;

  logic [RR_W-1:0]    own_idx;
  logic               own_valid;
  logic               own_last;
  logic               own_cancel;
  logic [DATA_W-1:0]  own_data;
  logic [KEEP_W-1:0]  own_keep;

  logic               in_send;
  logic               frame_end;
  logic [RR_W-1:0]    rr_next;

  mac_rr_pick #(
    .REQ_N (REQ_N),
    .RR_W  (RR_W)
  ) u_pick (
    .req    (req_valid_i),
    .rr_ptr (rr_q),
    .pick   (pick),
    .any    (pick_any)
  );

  // Select the current owner's stream; everything reads zero when nobody holds the grant
  always_comb begin
    own_idx    = '0;
    own_valid  = 1'b0;
    own_last   = 1'b0;
    own_cancel = 1'b0;
    own_data   = '0;
    own_keep   = '0;
    for (int r = 0; r < REQ_N; r++) begin
      if (grant_q[r]) begin
        own_idx    = RR_W'(r);
        own_valid  = req_valid_i[r];
        own_last   = req_last_i[r];
        own_cancel = req_cancel_i[r];
        own_data   = req_data_i[r*DATA_W +: DATA_W];
        own_keep   = req_keep_i[r*KEEP_W +: KEEP_W];
      end
    end
  end

  // Next-state logic and datapath outputs; cancel overrides last and drops the beat
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    ifg_cnt_d    = ifg_cnt_q;
    in_send      = (state_q == ST_SEND);
    frame_end    = own_cancel | (own_valid & mac_ready_i & own_last);
    rr_next      = (own_idx == RR_LAST) ? '0 : own_idx + RR_W'(1);

    mac_cancel_o = in_send & own_cancel;
    mac_valid_o  = in_send & own_valid & ~own_cancel;
    mac_last_o   = in_send & own_last & ~own_cancel;
    mac_data_o   = in_send ? own_data : '0;
    mac_keep_o   = in_send ? own_keep : '0;
    req_ready_o  = in_send ? (grant_q & {REQ_N{own_cancel | mac_ready_i}}) : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (frame_end) begin
          grant_d   = '0;
          rr_d      = rr_next;
          ifg_cnt_d = IFG_LOAD;
          state_d   = ST_IFG;
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant, round-robin pointer and gap counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      ifg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - directed self-checking bench for mac_tx_arbiter
module tb_mac_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_keep_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_cancel_i;
  logic [1:0]  req_ready_o;
  logic        mac_ready_i;
  logic        mac_valid_o;
  logic [15:0] mac_data_o;
  logic [1:0]  mac_keep_o;
  logic        mac_last_o;
  logic        mac_cancel_o;
  logic [1:0]  grant_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  mac_tx_arbiter #(
    .REQ_N  (2),
    .DATA_W (16),
    .KEEP_W (2),
    .IFG_N  (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_keep_i   (req_keep_i),
    .req_last_i   (req_last_i),
    .req_cancel_i (req_cancel_i),
    .req_ready_o  (req_ready_o),
    .mac_ready_i  (mac_ready_i),
    .mac_valid_o  (mac_valid_o),
    .mac_data_o   (mac_data_o),
    .mac_keep_o   (mac_keep_o),
    .mac_last_o   (mac_last_o),
    .mac_cancel_o (mac_cancel_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (grant_o == 2'b00 && n < 30) begin
      step();
      n++;
    end
    chk(tag, 32'(grant_o), 32'(exp));
    chk({tag, "_gap"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic frame(input int r, input int nb, input logic [15:0] base, input string tag);
    for (int b = 0; b < nb; b++) begin
      req_data_i[r*16 +: 16] = base + 16'(b);
      req_last_i[r]          = (b == nb - 1);
      #1;
      chk({tag, "_valid"}, 32'(mac_valid_o), 32'd1);
      chk({tag, "_data"},  32'(mac_data_o),  32'(base + 16'(b)));
      chk({tag, "_last"},  32'(mac_last_o),  32'(b == nb - 1));
      chk({tag, "_ready"}, 32'(req_ready_o), 32'(2'b01 << r));
      step();
    end
    req_last_i[r] = 1'b0;
  endtask

  initial begin
    int b;
    reset        = 1'b1;
    req_valid_i  = 2'b00;
    req_data_i   = '0;
    req_keep_i   = 4'hF;
    req_last_i   = 2'b00;
    req_cancel_i = 2'b00;
    mac_ready_i  = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_valid", 32'(mac_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);

    // 1: single frame from requester 0, 4 beats, then 6-cycle gap
    req_valid_i = 2'b01;
    req_data_i[15:0] = 16'hA000;
    #1;
    chk("t1_idle_valid", 32'(mac_valid_o), 32'd0);
    chk("t1_idle_ready", 32'(req_ready_o), 32'd0);
    wait_grant(2'b01, 1, "t1_grant");
    chk("t1_keep", 32'(mac_keep_o), 32'h3);
    frame(0, 4, 16'hA000, "t1");
    req_valid_i = 2'b00;
    for (int i = 0; i < 6; i++) begin
      chk("t1_ifg_busy", 32'(busy_o), 32'd1);
      chk("t1_ifg_valid", 32'(mac_valid_o), 32'd0);
      step();
    end
    chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // 2: contention from a fresh pointer -> strict 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid_i = 2'b11;
    wait_grant(2'b01, 1, "t2_g0a");
    frame(0, 2, 16'h1000, "t2_f0a");
    chk("t2_ifg_ready", 32'(req_ready_o), 32'd0);
    wait_grant(2'b10, 7, "t2_g1a");
    frame(1, 3, 16'h2000, "t2_f1a");
    wait_grant(2'b01, 7, "t2_g0b");
    frame(0, 2, 16'h1100, "t2_f0b");
    wait_grant(2'b10, 7, "t2_g1b");
    frame(1, 2, 16'h2100, "t2_f1b");

    // 3: backpressure 1,0,1,0 on a 4-beat frame from requester 0
    req_valid_i = 2'b01;
    wait_grant(2'b01, 7, "t3_grant");
    b = 0;
    for (int c = 0; c < 7; c++) begin
      mac_ready_i      = (c % 2 == 0);
      req_data_i[15:0] = 16'h3000 + 16'(b);
      req_last_i[0]    = (b == 3);
      #1;
      chk("t3_ready", 32'(req_ready_o), {31'd0, mac_ready_i});
      chk("t3_data",  32'(mac_data_o),  32'(16'h3000 + 16'(b)));
      if (mac_ready_i) b++;
      step();
    end
    req_last_i  = 2'b00;
    mac_ready_i = 1'b1;
    chk("t3_ifg_grant", 32'(grant_o), 32'd0);
    chk("t3_ifg_busy",  32'(busy_o),  32'd1);

    // 4: cancel on beat 2 of a requester-1 frame, then cancel+last together
    req_valid_i = 2'b10;
    wait_grant(2'b10, 7, "t4_grant");
    req_data_i[31:16] = 16'h4000;
    #1;
    chk("t4_b0_valid", 32'(mac_valid_o), 32'd1);
    step();
    req_data_i[31:16] = 16'h4001;
    req_cancel_i      = 2'b10;
    mac_ready_i       = 1'b0;
    #1;
    chk("t4_cancel",       32'(mac_cancel_o), 32'd1);
    chk("t4_cancel_valid", 32'(mac_valid_o),  32'd0);
    chk("t4_cancel_ready", 32'(req_ready_o),  32'h2);
    step();
    req_cancel_i = 2'b00;
    mac_ready_i  = 1'b1;
    #1;
    chk("t4_cancel_pulse", 32'(mac_cancel_o), 32'd0);
    chk("t4_ifg_grant",    32'(grant_o),      32'd0);
    chk("t4_ifg_busy",     32'(busy_o),       32'd1);
    req_valid_i = 2'b11;
    wait_grant(2'b01, 7, "t4_rr_adv");
    req_cancel_i = 2'b01;
    req_last_i   = 2'b01;
    #1;
    chk("t4_cl_cancel", 32'(mac_cancel_o), 32'd1);
    chk("t4_cl_last",   32'(mac_last_o),   32'd0);
    chk("t4_cl_valid",  32'(mac_valid_o),  32'd0);
    step();
    req_cancel_i = 2'b00;
    req_last_i   = 2'b00;

    // 5: non-owner cancel/valid ignored, owner bubble holds grant
    wait_grant(2'b10, 7, "t5_grant");
    req_cancel_i      = 2'b01;
    req_data_i[31:16] = 16'h5000;
    #1;
    chk("t5_cancel", 32'(mac_cancel_o), 32'd0);
    chk("t5_ready",  32'(req_ready_o),  32'h2);
    chk("t5_data",   32'(mac_data_o),   32'h5000);
    chk("t5_valid",  32'(mac_valid_o),  32'd1);
    step();
    req_cancel_i = 2'b00;
    chk("t5_hold", 32'(grant_o), 32'h2);
    req_valid_i = 2'b01;
    #1;
    chk("t5_bubble_valid", 32'(mac_valid_o), 32'd0);
    step();
    chk("t5_bubble_grant", 32'(grant_o), 32'h2);
    req_valid_i = 2'b11;

    // 6: reset mid-SEND clears everything, next grant goes to requester 0
    reset = 1'b1;
    step();
    chk("t6_grant",  32'(grant_o),      32'd0);
    chk("t6_busy",   32'(busy_o),       32'd0);
    chk("t6_valid",  32'(mac_valid_o),  32'd0);
    chk("t6_ready",  32'(req_ready_o),  32'd0);
    chk("t6_cancel", 32'(mac_cancel_o), 32'd0);
    chk("t6_data",   32'(mac_data_o),   32'd0);
    chk("t6_keep",   32'(mac_keep_o),   32'd0);
    chk("t6_last",   32'(mac_last_o),   32'd0);
    reset = 1'b0;
    wait_grant(2'b01, 1, "t6_regrant");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
